// File: rtl/spi_multi_rx.sv
// spi_multi_rx
//   NUM_CH independent SPI mode-0 slave receivers, oversampled in the sysclk
//   domain. Each channel assembles MSB-first words into its own FIFO, echoes
//   its previous word on MISO, and keeps sticky overflow / frame-error flags.
//   A round-robin arbiter merges the FIFOs into one valid/ready stream tagged
//   with the source channel.
//
// Ports
//   sysclk, reset        system clock, asynchronous active-high reset
//   SCLK, MOSI, CS_n     per-channel SPI inputs (asynchronous to sysclk)
//   MISO                 per-channel echo of the previously received word
//   m_valid/m_ready      output handshake
//   m_data, m_chan       received word and its source channel
//   ovf_flag             sticky: word dropped because the channel FIFO was full
//   frame_err            sticky: CS_n released in the middle of a word
//   flag_clr             per-channel pulse clearing both sticky flags

module spi_multi_rx #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] SCLK,
    input  logic [NUM_CH-1:0] MOSI,
    input  logic [NUM_CH-1:0] CS_n,
    output logic [NUM_CH-1:0] MISO,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CH_W-1:0]   m_chan,
    output logic [NUM_CH-1:0] ovf_flag,
    output logic [NUM_CH-1:0] frame_err,
    input  logic [NUM_CH-1:0] flag_clr
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [NUM_CH-1:0] sclk_s1, sclk_s2, sclk_s3;
    logic [NUM_CH-1:0] mosi_s1, mosi_s2;
    logic [NUM_CH-1:0] cs_s1, cs_s2, cs_s3;
    logic [NUM_CH-1:0] sclk_rise, sclk_fall, cs_rise;

    logic [DATA_W-1:0] shreg   [NUM_CH];
    logic [CNT_W-1:0]  bit_cnt [NUM_CH];
    logic [DATA_W-1:0] echo    [NUM_CH];
    logic [NUM_CH-1:0] wr_pend;

    logic [DATA_W-1:0] fifo_mem [NUM_CH][FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr   [NUM_CH];
    logic [PTR_W:0]    rd_ptr   [NUM_CH];
    logic [NUM_CH-1:0] fifo_empty, fifo_full, fifo_wr, pop;
    logic [NUM_CH-1:0] ovf_set, ferr_set;

    logic [CH_W-1:0]   arb_ptr, grant, cand;
    logic              any_req, load_en;
    logic [DATA_W-1:0] head_data;

    // CS_n synchronisers idle high so a released bus looks inactive after reset.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sclk_s1 <= '0; sclk_s2 <= '0; sclk_s3 <= '0;
            mosi_s1 <= '0; mosi_s2 <= '0;
            cs_s1   <= '1; cs_s2   <= '1; cs_s3   <= '1;
        end else begin
            sclk_s1 <= SCLK;    sclk_s2 <= sclk_s1; sclk_s3 <= sclk_s2;
            mosi_s1 <= MOSI;    mosi_s2 <= mosi_s1;
            cs_s1   <= CS_n;    cs_s2   <= cs_s1;   cs_s3   <= cs_s2;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;
    assign cs_rise   = cs_s2 & ~cs_s3;

    always_comb begin
        ferr_set = '0;
        ovf_set  = '0;
        fifo_wr  = '0;
        MISO     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ferr_set[c]   = cs_rise[c] && (bit_cnt[c] != '0);
            // A pop in the same cycle frees a slot, so a full FIFO still accepts.
            fifo_wr[c]    = wr_pend[c] && (!fifo_full[c] || pop[c]);
            ovf_set[c]    = wr_pend[c] && fifo_full[c] && !pop[c];
            MISO[c]       = ~cs_s2[c] & echo[c][DATA_W-1];
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            wr_pend   <= '0;
            ovf_flag  <= '0;
            frame_err <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                shreg[c]   <= '0;
                bit_cnt[c] <= '0;
                echo[c]    <= '0;
            end
        end else begin
            wr_pend   <= '0;
            ovf_flag  <= (ovf_flag & ~flag_clr) | ovf_set;
            frame_err <= (frame_err & ~flag_clr) | ferr_set;
            for (int c = 0; c < NUM_CH; c++) begin
                if (cs_s2[c]) begin
                    bit_cnt[c] <= '0;
                end else if (sclk_rise[c]) begin
                    shreg[c] <= {shreg[c][DATA_W-2:0], mosi_s2[c]};
                    if (bit_cnt[c] == CNT_W'(DATA_W - 1)) begin
                        bit_cnt[c] <= '0;
                        wr_pend[c] <= 1'b1;
                    end else begin
                        bit_cnt[c] <= bit_cnt[c] + CNT_W'(1);
                    end
                end
                // The trailing fall of a completed word (counter back at 0) does
                // not shift, so the MSB of the new echo is on MISO for the first
                // rise of the next word.
                if (wr_pend[c]) begin
                    echo[c] <= shreg[c];
                end else if (sclk_fall[c] && !cs_s2[c] && (bit_cnt[c] != '0)) begin
                    echo[c] <= {echo[c][DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    always_comb begin
        fifo_empty = '0;
        fifo_full  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            fifo_empty[c] = (wr_ptr[c] == rd_ptr[c]);
            fifo_full[c]  = (wr_ptr[c][PTR_W] != rd_ptr[c][PTR_W]) &&
                            (wr_ptr[c][PTR_W-1:0] == rd_ptr[c][PTR_W-1:0]);
        end
    end

    always_ff @(posedge sysclk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (fifo_wr[c]) fifo_mem[c][wr_ptr[c][PTR_W-1:0]] <= shreg[c];
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (fifo_wr[c]) wr_ptr[c] <= wr_ptr[c] + (PTR_W + 1)'(1);
                if (pop[c])     rd_ptr[c] <= rd_ptr[c] + (PTR_W + 1)'(1);
            end
        end
    end

    // Search starts one past the last winner and wraps.
    always_comb begin
        any_req   = 1'b0;
        grant     = arb_ptr;
        cand      = '0;
        pop       = '0;
        load_en   = !m_valid || m_ready;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = CH_W'((int'(arb_ptr) + i) % NUM_CH);
            if (!any_req && !fifo_empty[cand]) begin
                any_req = 1'b1;
                grant   = cand;
            end
        end
        head_data = fifo_mem[grant][rd_ptr[grant][PTR_W-1:0]];
        if (load_en && any_req) pop[grant] = 1'b1;
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_chan  <= '0;
            arb_ptr <= CH_W'(NUM_CH - 1);
        end else if (load_en) begin
            m_valid <= any_req;
            if (any_req) begin
                m_data  <= head_data;
                m_chan  <= grant;
                arb_ptr <= grant;
            end
        end
    end

endmodule
